// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator driven by a sampled pixel-rate wave
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_clk_in,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last count of each axis; the counters park here in reset so the
    // first pixel tick lands on (0,0).
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Decode bounds are 11 bits wide so a sync end at exactly 1024 still compares correctly.
    localparam logic [10:0] H_VIS_END = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic       pix_prev;
    logic       tick;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic [10:0] h_ext;
    logic [10:0] v_ext;
    logic       hs_active;
    logic       vs_active;
    logic       vis_next;

    // Rising-edge detect on the sampled pixel wave, then next-count and decode logic.
    always_comb begin
        tick   = pix_clk_in & ~pix_prev;
        h_next = h_cnt;
        v_next = v_cnt;
        if (tick) begin
            if (h_cnt == H_LAST) begin
                h_next = 10'd0;
                if (v_cnt == V_LAST) begin
                    v_next = 10'd0;
                end else begin
                    v_next = v_cnt + 10'd1;
                end
            end else begin
                h_next = h_cnt + 10'd1;
            end
        end
        h_ext     = {1'b0, h_next};
        v_ext     = {1'b0, v_next};
        hs_active = (h_ext >= HS_BEG) && (h_ext < HS_END);
        vs_active = (v_ext >= VS_BEG) && (v_ext < VS_END);
        vis_next  = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
    end

    // Register counters and every output from the post-tick values; reset wins over a tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_prev    <= 1'b1;
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_prev    <= pix_clk_in;
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            hsync       <= hs_active ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_active ? SYNC_POL : ~SYNC_POL;
            video_on    <= vis_next;
            line_start  <= tick && (h_next == 10'd0);
            frame_start <= tick && (h_next == 10'd0) && (v_next == 10'd0);
        end
    end

    assign x = h_cnt;
    assign y = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized model-checked bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic pix;

    always #5 clk = ~clk;

    // default-geometry instance
    logic       hs_a, vs_a, von_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    // tiny-geometry instance with active-high sync, so whole frames wrap quickly
    logic       hs_b, vs_b, von_b, ls_b, fs_b;
    logic [9:0] x_b, y_b;

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n), .pix_clk_in(pix),
        .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
        .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_clk_in(pix),
        .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
        .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } obs_t;

    int vectors = 0;
    int miscompares = 0;
    int hs_low = 0;
    bit done = 1'b0;

    // Raster position is a pure function of how many pixel ticks happened since reset.
    function automatic obs_t model(input int n, input bit tick,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input bit pol);
        obs_t o;
        int ht, vt, h, v;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (n == 0) begin
            h = ht - 1;
            v = vt - 1;
        end else begin
            h = (n - 1) % ht;
            v = ((n - 1) / ht) % vt;
        end
        o.x   = 10'(h);
        o.y   = 10'(v);
        o.hs  = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
        o.vs  = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
        o.von = (h < ha) && (v < va);
        o.ls  = tick && (h == 0);
        o.fs  = tick && (h == 0) && (v == 0);
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s t=%0t got hs=%b vs=%b von=%b x=%0d y=%0d ls=%b fs=%b want hs=%b vs=%b von=%b x=%0d y=%0d ls=%b fs=%b",
                     name, $time, act.hs, act.vs, act.von, act.x, act.y, act.ls, act.fs,
                     req.hs, req.vs, req.von, req.x, req.y, req.ls, req.fs);
        end
    endtask

    task automatic check_val(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, req);
        end
    endtask

    // Per-cycle model compare: inputs sampled at each edge, outputs checked on the falling edge.
    initial begin
        int  n;
        bit  prev, tk;
        obs_t ea, eb, aa, ab;
        n = 0;
        prev = 1'b1;
        while (!done) begin
            @(posedge clk);
            tk = 1'b0;
            if (!rst_n) begin
                n = 0;
                prev = 1'b1;
            end else begin
                if (pix && !prev) begin
                    n++;
                    tk = 1'b1;
                end
                prev = pix;
            end
            @(negedge clk);
            ea = model(n, tk, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
            eb = model(n, tk, 8, 2, 3, 2, 6, 1, 2, 1, 1'b1);
            aa = '{hs: hs_a, vs: vs_a, von: von_a, x: x_a, y: y_a, ls: ls_a, fs: fs_a};
            ab = '{hs: hs_b, vs: vs_b, von: von_b, x: x_b, y: y_b, ls: ls_b, fs: fs_b};
            check_obs("model_default", aa, ea);
            check_obs("model_small", ab, eb);
        end
    end

    // One clk of stimulus; also counts default-geometry hsync-low clocks.
    task automatic step();
        @(negedge clk);
        if (hs_a == 1'b0) hs_low++;
        @(posedge clk);
        #1;
    endtask

    task automatic period(input int lo, input int hi);
        pix = 1'b0;
        repeat (lo) step();
        pix = 1'b1;
        repeat (hi) step();
    endtask

    initial begin
        rst_n = 1'b0;
        pix   = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (10) step();
        @(negedge clk);
        check_val("idle_x", int'(x_a), 799);
        check_val("idle_y", int'(y_a), 524);
        check_val("idle_hsync", int'(hs_a), 1);
        check_val("idle_vsync", int'(vs_a), 1);
        check_val("idle_strobes", int'({ls_a, fs_a, von_a}), 0);
        @(posedge clk); #1;

        // first rising edge lands on (0,0) with both strobes for one clk
        pix = 1'b0;
        repeat (2) step();
        pix = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("first_x", int'(x_a), 0);
        check_val("first_y", int'(y_a), 0);
        check_val("first_video_on", int'(von_a), 1);
        check_val("first_strobes", int'({ls_a, fs_a}), 3);
        @(negedge clk);
        check_val("strobe_width", int'({ls_a, fs_a}), 0);
        @(posedge clk); #1;

        // one full line at period 4: hsync low for 96 ticks of 4 clks
        hs_low = 0;
        repeat (800) period(2, 2);
        check_val("hsync_low_clks", hs_low, 384);
        check_val("line_wrap_x", int'(x_a), 0);
        check_val("line_wrap_y", int'(y_a), 1);

        // frozen wave freezes the raster
        pix = 1'b0;
        repeat (100) step();
        check_val("freeze_x", int'(x_a), 0);
        check_val("freeze_y", int'(y_a), 1);

        // randomized pixel periods with occasional resets, including reset during a tick
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                pix = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 3)) step();
                rst_n = 1'b1;
            end
            period($urandom_range(1, 4), $urandom_range(1, 4));
        end

        // reset mid-raster, then first tick restarts the frame
        period(2, 2);
        rst_n = 1'b0;
        step();
        check_val("rst_x", int'(x_a), 799);
        check_val("rst_y", int'(y_a), 524);
        check_val("rst_small_x", int'(x_b), 14);
        rst_n = 1'b1;
        pix = 1'b0;
        repeat (2) step();
        pix = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("restart_xy", int'({x_a, y_a}), 0);
        check_val("restart_fs", int'(fs_a), 1);
        @(posedge clk); #1;
        repeat (4) step();

        done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
